// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP read sequencer.
package xadc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } xadc_seq_state_t;

  localparam int XADC_DRP_AW = 7;
  localparam int XADC_DRP_DW = 16;
  localparam int XADC_CH_W   = 5;
  localparam int XADC_VAUX0  = 16;

endpackage

// File: rtl/xadc_ch_accum.sv
// Per-channel accumulator/count bank for the averaging build (XADC_AVG_EN).
// The result and last flag are combinational for the addressed channel.
// On add, the channel either banks the sample or, on its final sample, clears.
module xadc_ch_accum #(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   idx,
  input  logic              add,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result,
  output logic              last
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [ACC_W-1:0] sum;

  // Running sum of the addressed channel plus the incoming sample.
  always_comb begin
    sum    = acc_q[idx] + ACC_W'(sample);
    result = DATA_W'(sum >> AVG_LOG2);
    last   = (AVG_LOG2 == 0) ? 1'b1 : (cnt_q[idx] == {CNT_W{1'b1}});
  end

  // Bank update: accumulate non-final samples, clear after the final one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (add) begin
      if (last) begin
        acc_q[idx] <= '0;
        cnt_q[idx] <= '0;
      end else begin
        acc_q[idx] <= sum;
        cnt_q[idx] <= cnt_q[idx] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: one DRP read per in-range EOC, result on a
// channel-tagged valid/ready stream. Optional per-channel averaging is
// enabled by defining the macro XADC_AVG_EN.
//
// Output handshake: a result is presented while valid_o is high; data_o and
// chan_o stay stable until the cycle where valid_o && ready_i, after which
// valid_o drops on the next cycle.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 4,
  parameter int CH_BASE  = 16,
  parameter int TIMEOUT  = 64,
  parameter int AVG_LOG2 = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   eoc_i,
  input  logic [XADC_CH_W-1:0]   channel_i,
  output logic                   drp_den_o,
  output logic [XADC_DRP_AW-1:0] drp_daddr_o,
  input  logic                   drp_drdy_i,
  input  logic [XADC_DRP_DW-1:0] drp_do_i,
  output logic [DATA_W-1:0]      data_o,
  output logic [CH_W-1:0]        chan_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o,
  output logic                   timeout_o,
  output xadc_seq_state_t        state_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  xadc_seq_state_t        state_q, state_d;
  logic [XADC_CH_W-1:0]   chan_q;
  logic [CH_W-1:0]        idx_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      data_q;
  logic [XADC_DRP_AW-1:0] daddr_q;
  logic                   den_q, timeout_q, overrun_q;
  logic                   den_d, timeout_d, overrun_d;
  logic                   in_range, accept, capture;
  logic [DATA_W-1:0]      sample, out_data;
  logic                   avg_last;
  logic                   do_unused;

  assign in_range  = ({1'b0, channel_i} >= 6'(CH_BASE)) &&
                     ({1'b0, channel_i} <  6'(CH_BASE + NUM_CH));
  assign sample    = drp_do_i[15 -: DATA_W];
  assign do_unused = ^drp_do_i;

`ifdef XADC_AVG_EN
  xadc_ch_accum #(
    .DATA_W   (DATA_W),
    .NUM_CH   (NUM_CH),
    .AVG_LOG2 (AVG_LOG2),
    .CH_W     (CH_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .idx    (idx_q),
    .add    (capture),
    .sample (sample),
    .result (out_data),
    .last   (avg_last)
  );
`else
  localparam int AVG_LOG2_UNUSED = AVG_LOG2;
  assign avg_last = 1'b1;
  assign out_data = sample;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    den_d     = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: if (eoc_i && in_range) begin
        accept  = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        den_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (drp_drdy_i) begin
          capture = 1'b1;
          state_d = avg_last ? OUT : IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      OUT: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (eoc_i && in_range && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // Datapath: registered strobes, captured channel, DRP address, timer, result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      den_q     <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      chan_q    <= '0;
      idx_q     <= '0;
      daddr_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
    end else begin
      den_q     <= den_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      if (accept) begin
        chan_q <= channel_i;
        idx_q  <= CH_W'(channel_i - XADC_CH_W'(CH_BASE));
      end
      if (state_q == REQ) begin
        daddr_q <= {2'b00, chan_q};
        cnt_q   <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture && avg_last) data_q <= out_data;
    end
  end

  assign drp_den_o   = den_q;
  assign drp_daddr_o = daddr_q;
  assign timeout_o   = timeout_q;
  assign overrun_o   = overrun_q;
  assign data_o      = data_q;
  assign chan_o      = idx_q;
  assign valid_o     = (state_q == OUT);
  assign state_o     = state_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer (default parameters). Sections that
// depend on averaging are selected by XADC_AVG_EN.
module tb_xadc_drp_sequencer;
  import xadc_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            eoc_i;
  logic [4:0]      channel_i;
  logic            drp_den_o;
  logic [6:0]      drp_daddr_o;
  logic            drp_drdy_i;
  logic [15:0]     drp_do_i;
  logic [11:0]     data_o;
  logic [1:0]      chan_o;
  logic            valid_o;
  logic            ready_i;
  logic            overrun_o;
  logic            timeout_o;
  xadc_seq_state_t state_o;

  int n_vec = 0;
  int n_err = 0;

  // Clock generation.
  always #5 clk = ~clk;

  xadc_drp_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .eoc_i       (eoc_i),
    .channel_i   (channel_i),
    .drp_den_o   (drp_den_o),
    .drp_daddr_o (drp_daddr_o),
    .drp_drdy_i  (drp_drdy_i),
    .drp_do_i    (drp_do_i),
    .data_o      (data_o),
    .chan_o      (chan_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overrun_o   (overrun_o),
    .timeout_o   (timeout_o),
    .state_o     (state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one in-range EOC and check the den pulse lands two cycles later.
  task automatic issue(input logic [4:0] ch);
    eoc_i     = 1'b1;
    channel_i = ch;
    step();
    eoc_i = 1'b0;
    check("den_early", 32'(drp_den_o), 32'd0);
    step();
    check("den_pulse", 32'(drp_den_o), 32'd1);
    check("daddr", 32'(drp_daddr_o), 32'(ch));
  endtask

  // One full read: issue, then drdy one cycle after the den cycle.
  task automatic read_ch(input logic [4:0] ch, input logic [15:0] dov);
    issue(ch);
    step();
    drp_drdy_i = 1'b1;
    drp_do_i   = dov;
    step();
    drp_drdy_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int extra_den;
    rst        = 1'b0;
    eoc_i      = 1'b0;
    channel_i  = '0;
    drp_drdy_i = 1'b0;
    drp_do_i   = '0;
    ready_i    = 1'b1;
    step();
    step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_den", 32'(drp_den_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_chan", 32'(chan_o), 32'd0);
    check("rst_daddr", 32'(drp_daddr_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    rst = 1'b1;
    step();

`ifndef XADC_AVG_EN
    // Raw read on channel 17.
    issue(5'd17);
    step();
    check("den_one_cycle", 32'(drp_den_o), 32'd0);
    step();
    step();
    drp_drdy_i = 1'b1;
    drp_do_i   = 16'hABC0;
    check("valid_before_drdy", 32'(valid_o), 32'd0);
    step();
    drp_drdy_i = 1'b0;
    check("raw_valid", 32'(valid_o), 32'd1);
    check("raw_data", 32'(data_o), 32'hABC);
    check("raw_chan", 32'(chan_o), 32'd1);
    step();
    check("raw_valid_drop", 32'(valid_o), 32'd0);
    check("raw_idle", 32'(state_o), 32'(IDLE));

    // Backpressure with an overrun during the stall.
    ready_i = 1'b0;
    read_ch(5'd18, 16'h5550);
    check("bp_valid", 32'(valid_o), 32'd1);
    check("bp_data", 32'(data_o), 32'h555);
    check("bp_chan", 32'(chan_o), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        eoc_i     = 1'b1;
        channel_i = 5'd16;
      end
      step();
      eoc_i = 1'b0;
      check("bp_hold_valid", 32'(valid_o), 32'd1);
      check("bp_hold_data", 32'(data_o), 32'h555);
      check("bp_hold_chan", 32'(chan_o), 32'd2);
      check("bp_no_den", 32'(drp_den_o), 32'd0);
      check("bp_overrun", 32'(overrun_o), (i == 1) ? 32'd1 : 32'd0);
    end
    // Handshake and an in-range EOC in the same cycle: EOC is an overrun.
    ready_i   = 1'b1;
    eoc_i     = 1'b1;
    channel_i = 5'd16;
    step();
    eoc_i = 1'b0;
    check("hs_valid_drop", 32'(valid_o), 32'd0);
    check("hs_overrun", 32'(overrun_o), 32'd1);
    check("hs_idle", 32'(state_o), 32'(IDLE));
    step();
    check("hs_no_den1", 32'(drp_den_o), 32'd0);
    check("hs_overrun_clear", 32'(overrun_o), 32'd0);
    step();
    check("hs_no_den2", 32'(drp_den_o), 32'd0);
`endif

    // Channel window: 3 and 20 are outside 16..19.
    eoc_i     = 1'b1;
    channel_i = 5'd3;
    step();
    eoc_i = 1'b0;
    check("win_lo_overrun", 32'(overrun_o), 32'd0);
    check("win_lo_state", 32'(state_o), 32'(IDLE));
    eoc_i     = 1'b1;
    channel_i = 5'd20;
    step();
    eoc_i = 1'b0;
    check("win_hi_state", 32'(state_o), 32'(IDLE));
    step();
    check("win_no_den1", 32'(drp_den_o), 32'd0);
    check("win_hi_overrun", 32'(overrun_o), 32'd0);
    step();
    check("win_no_den2", 32'(drp_den_o), 32'd0);
    check("win_no_valid", 32'(valid_o), 32'd0);

    // drdy while IDLE is ignored.
    drp_drdy_i = 1'b1;
    drp_do_i   = 16'h1230;
    step();
    drp_drdy_i = 1'b0;
    check("idle_drdy_valid", 32'(valid_o), 32'd0);
    step();
    check("idle_drdy_state", 32'(state_o), 32'(IDLE));

    // Timeout: no drdy.
    issue(5'd19);
    lat       = 0;
    extra_den = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (drp_den_o) extra_den++;
      if (timeout_o) begin
        lat = i;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'd64);
    check("timeout_no_den", 32'(extra_den), 32'd0);
    check("timeout_idle", 32'(state_o), 32'(IDLE));
    check("timeout_no_valid", 32'(valid_o), 32'd0);
    step();
    check("timeout_pulse_end", 32'(timeout_o), 32'd0);

    // Next EOC after a timeout is serviced.
`ifndef XADC_AVG_EN
    read_ch(5'd16, 16'h1230);
    check("post_to_valid", 32'(valid_o), 32'd1);
    check("post_to_data", 32'(data_o), 32'h123);
    check("post_to_chan", 32'(chan_o), 32'd0);
    step();
    check("post_to_drop", 32'(valid_o), 32'd0);

    // drdy on the last allowed cycle wins over the timeout.
    issue(5'd17);
    for (int i = 0; i < 63; i++) step();
    drp_drdy_i = 1'b1;
    drp_do_i   = 16'hFFF0;
    step();
    drp_drdy_i = 1'b0;
    check("edge_no_timeout", 32'(timeout_o), 32'd0);
    check("edge_valid", 32'(valid_o), 32'd1);
    check("edge_data", 32'(data_o), 32'hFFF);
    step();
    check("edge_no_timeout2", 32'(timeout_o), 32'd0);
    check("edge_drop", 32'(valid_o), 32'd0);
`else
    read_ch(5'd16, 16'h0000);
    check("post_to_no_valid", 32'(valid_o), 32'd0);
    check("post_to_idle", 32'(state_o), 32'(IDLE));

    // Averaging: ch 18 samples 100,101,102,104 -> 101; ch 16 interleaved.
    read_ch(5'd18, 16'h1000);
    check("avg_s1_no_valid", 32'(valid_o), 32'd0);
    read_ch(5'd16, 16'hFFF0);
    check("avg_i1_no_valid", 32'(valid_o), 32'd0);
    read_ch(5'd18, 16'h1010);
    check("avg_s2_no_valid", 32'(valid_o), 32'd0);
    read_ch(5'd16, 16'hFFF0);
    check("avg_i2_no_valid", 32'(valid_o), 32'd0);
    read_ch(5'd18, 16'h1020);
    check("avg_s3_no_valid", 32'(valid_o), 32'd0);
    read_ch(5'd18, 16'h1040);
    check("avg_valid", 32'(valid_o), 32'd1);
    check("avg_data", 32'(data_o), 32'h101);
    check("avg_chan", 32'(chan_o), 32'd2);
    step();
    check("avg_drop", 32'(valid_o), 32'd0);
    // ch 16: 000 + FFF + FFF + FFF = 2FFD, >>2 = BFF.
    read_ch(5'd16, 16'hFFF0);
    check("avg16_valid", 32'(valid_o), 32'd1);
    check("avg16_data", 32'(data_o), 32'hBFF);
    check("avg16_chan", 32'(chan_o), 32'd0);
    step();
`endif

    // Reset while in WAIT; a late drdy afterwards is ignored.
    issue(5'd17);
    step();
    rst = 1'b0;
    #1;
    check("mrst_state", 32'(state_o), 32'(IDLE));
    check("mrst_valid", 32'(valid_o), 32'd0);
    check("mrst_den", 32'(drp_den_o), 32'd0);
    check("mrst_daddr", 32'(drp_daddr_o), 32'd0);
    check("mrst_data", 32'(data_o), 32'd0);
    check("mrst_chan", 32'(chan_o), 32'd0);
    check("mrst_timeout", 32'(timeout_o), 32'd0);
    check("mrst_overrun", 32'(overrun_o), 32'd0);
    step();
    rst        = 1'b1;
    drp_drdy_i = 1'b1;
    drp_do_i   = 16'hABC0;
    step();
    drp_drdy_i = 1'b0;
    check("late_drdy_valid", 32'(valid_o), 32'd0);
    step();
    check("late_drdy_valid2", 32'(valid_o), 32'd0);
    check("late_drdy_state", 32'(state_o), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
